// File: rtl/lenet_fc3_argmax.sv
// lenet_fc3_argmax: final LeNet fully-connected layer (84 -> 10) plus argmax.
// One 8x8 signed MAC per cycle. Each of the ten neurons takes 87 cycles:
// a bias fetch, a bias load, 84 MAC cycles and a compare.
// Optional build macro: FC3_SCORE_READBACK_EN adds a readable logit register file.
module lenet_fc3_argmax (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [6:0]         in_addr,
  input  logic signed [7:0]  in_data,
  output logic [9:0]         w_addr,
  input  logic signed [7:0]  w_data,
  output logic [3:0]         b_addr,
  input  logic signed [31:0] b_data,
  output logic [3:0]         digit,
  output logic               digit_valid,
  output logic signed [31:0] max_score
`ifdef FC3_SCORE_READBACK_EN
  ,
  input  logic [3:0]         score_rd_addr,
  output logic [31:0]        score_rd_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_BIAS = 3'd1,
    S_BIAS_WAIT = 3'd2,
    S_MAC       = 3'd3,
    S_COMPARE   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Sign-extend a 16-bit product into the 32-bit accumulator domain.
  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         n_q, n_d;          // neuron index
  logic [6:0]         j_q, j_d;          // input index within neuron
  logic [9:0]         w_base_q, w_base_d; // n*84, kept incrementally
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] max_q, max_d;
  logic [3:0]         idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         digit_q, digit_d;
  logic               valid_q, valid_d;
  logic signed [31:0] score_q, score_d;
  logic [6:0]         in_addr_q, in_addr_d;
  logic [9:0]         w_addr_q, w_addr_d;
  logic [3:0]         b_addr_q, b_addr_d;
  logic signed [15:0] prod_s;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    j_d       = j_q;
    w_base_d  = w_base_q;
    acc_d     = acc_q;
    max_d     = max_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    digit_d   = digit_q;
    valid_d   = valid_q;
    score_d   = score_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    b_addr_d  = b_addr_q;
    prod_s    = in_data * w_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_BIAS;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          n_d      = 4'd0;
          w_base_d = 10'd0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD_BIAS: begin
        b_addr_d = n_q;
        state_d  = S_BIAS_WAIT;
      end
      S_BIAS_WAIT: begin
        acc_d     = b_data;
        in_addr_d = 7'd0;
        w_addr_d  = w_base_q;
        j_d       = 7'd0;
        state_d   = S_MAC;
      end
      S_MAC: begin
        // Accumulator wraps modulo 2^32 by construction.
        acc_d = acc_q + sext16(prod_s);
        if (j_q == 7'd83) begin
          state_d = S_COMPARE;
        end else begin
          j_d       = j_q + 7'd1;
          in_addr_d = j_q + 7'd1;
          w_addr_d  = w_base_q + {3'b000, j_q} + 10'd1;
          state_d   = S_MAC;
        end
      end
      S_COMPARE: begin
        // Strict greater-than keeps the lowest index on ties.
        if ((n_q == 4'd0) || (acc_q > max_q)) begin
          max_d = acc_q;
          idx_d = n_q;
        end else begin
          max_d = max_q;
          idx_d = idx_q;
        end
        if (n_q == 4'd9) begin
          state_d = S_DONE;
        end else begin
          n_d      = n_q + 4'd1;
          w_base_d = w_base_q + 10'd84;
          state_d  = S_LOAD_BIAS;
        end
      end
      S_DONE: begin
        digit_d = idx_q;
        score_d = max_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= 4'd0;
      j_q       <= 7'd0;
      w_base_q  <= 10'd0;
      acc_q     <= 32'sd0;
      max_q     <= 32'sd0;
      idx_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digit_q   <= 4'd0;
      valid_q   <= 1'b0;
      score_q   <= 32'sd0;
      in_addr_q <= 7'd0;
      w_addr_q  <= 10'd0;
      b_addr_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      j_q       <= j_d;
      w_base_q  <= w_base_d;
      acc_q     <= acc_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      score_q   <= score_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      b_addr_q  <= b_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign in_addr     = in_addr_q;
  assign w_addr      = w_addr_q;
  assign b_addr      = b_addr_q;
  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign max_score   = score_q;

`ifdef FC3_SCORE_READBACK_EN
  logic signed [31:0] logit_q [0:9];
  logic               logit_we_s;

  assign logit_we_s = (state_q == S_COMPARE);

  // Capture each finished logit for readback; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 10; k++) begin
        logit_q[k] <= 32'sd0;
      end
    end else if (logit_we_s) begin
      logit_q[n_q] <= acc_q;
    end else begin
      logit_q[n_q] <= logit_q[n_q];
    end
  end

  // Unpopulated addresses 10-15 read back as zero.
  always_comb begin
    if (score_rd_addr < 4'd10) begin
      score_rd_data = logit_q[score_rd_addr];
    end else begin
      score_rd_data = 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_lenet_fc3_argmax.sv
// Directed bench for lenet_fc3_argmax: table of weight/input patterns with
// hand-computed argmax results, plus abort, re-start and held-start sequences.
module tb_lenet_fc3_argmax;

  logic               clk;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic [6:0]         in_addr;
  logic signed [7:0]  in_data;
  logic [9:0]         w_addr;
  logic signed [7:0]  w_data;
  logic [3:0]         b_addr;
  logic signed [31:0] b_data;
  logic [3:0]         digit;
  logic               digit_valid;
  logic signed [31:0] max_score;
`ifdef FC3_SCORE_READBACK_EN
  logic [3:0]         score_rd_addr;
  logic [31:0]        score_rd_data;
`endif

  logic signed [7:0]  in_mem [0:83];
  logic signed [7:0]  w_mem  [0:839];
  logic signed [31:0] b_mem  [0:9];

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    int pat;
    int exp_digit;
    int exp_score;
  } vec_t;

  vec_t vecs [0:5];

  lenet_fc3_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .digit       (digit),
    .digit_valid (digit_valid),
    .max_score   (max_score)
`ifdef FC3_SCORE_READBACK_EN
    ,
    .score_rd_addr (score_rd_addr),
    .score_rd_data (score_rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data = (in_addr < 7'd84)  ? in_mem[in_addr] : 8'sd0;
  assign w_data  = (w_addr < 10'd840) ? w_mem[w_addr]   : 8'sd0;
  assign b_data  = (b_addr < 4'd10)   ? b_mem[b_addr]   : 32'sd0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int p);
    for (int j = 0; j < 84; j++) in_mem[j] = 8'sd0;
    for (int k = 0; k < 840; k++) w_mem[k] = 8'sd0;
    for (int n = 0; n < 10; n++) b_mem[n] = 32'sd0;
    case (p)
      0: begin
        for (int j = 0; j < 84; j++) in_mem[j] = 8'sd1;
        for (int k = 0; k < 840; k++) w_mem[k] = 8'sd1;
        for (int n = 0; n < 10; n++) b_mem[n] = n;
      end
      1: begin
        for (int j = 0; j < 84; j++) in_mem[j] = -8'sd128;
        for (int k = 0; k < 840; k++) w_mem[k] = -8'sd128;
      end
      2: begin
        b_mem[3]   = 32'sh7FFF_FFFF;
        in_mem[0]  = 8'sd1;
        w_mem[252] = 8'sd1;
      end
      3: begin
        for (int j = 0; j < 84; j++) in_mem[j] = 8'sd1;
        w_mem[504] = 8'sd5;
        b_mem[2]   = 32'sd4;
        b_mem[6]   = -32'sd1;
      end
      4: begin
        for (int n = 0; n < 10; n++) b_mem[n] = -50 - n;
      end
      5: begin
        for (int j = 0; j < 84; j++) in_mem[j] = (j % 2 == 0) ? 8'sd3 : -8'sd2;
        for (int j = 0; j < 84; j++) w_mem[8*84 + j] = 8'sd1;
      end
      default: begin
        for (int j = 0; j < 84; j++) in_mem[j] = 8'sd0;
      end
    endcase
  endtask

  // Launch one pass; cycle m is the m-th cycle after the edge sampling start.
  task automatic run(input string nm, input int exp_d, input int exp_s,
                     input int extra_start, input int abort_at, input bit hold);
    int ndone;
    int dmark;
    int dv_bad;
    int limit;
    ndone  = 0;
    dmark  = 0;
    dv_bad = 0;
    limit  = hold ? 1750 : 880;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk({nm, "_busy_c1"}, busy, 1);
    chk({nm, "_valid_c1"}, digit_valid, 0);
    for (int m = 1; m <= limit; m++) begin
      if (m > 1) @(negedge clk);
      if (done) begin
        ndone++;
        if (dmark == 0) dmark = m;
      end
      if (m < 872 && digit_valid) dv_bad++;
      if (hold && m == 873) begin
        chk({nm, "_relaunch_busy"}, busy, 1);
        start = 1'b0;
      end
      if (extra_start != 0) start = (m == extra_start);
      rst = (abort_at != 0) && (m == abort_at);
    end
    if (abort_at != 0) begin
      chk({nm, "_abort_ndone"}, ndone, 0);
      chk({nm, "_abort_busy"}, busy, 0);
      chk({nm, "_abort_digit"}, digit, 0);
      chk({nm, "_abort_valid"}, digit_valid, 0);
      chk({nm, "_abort_score"}, max_score, 0);
      chk({nm, "_abort_in_addr"}, in_addr, 0);
    end else begin
      chk({nm, "_done_cycle"}, dmark, 872);
      chk({nm, "_ndone"}, ndone, hold ? 2 : 1);
      chk({nm, "_valid_early"}, dv_bad, 0);
      chk({nm, "_digit"}, digit, exp_d);
      chk({nm, "_score"}, max_score, exp_s);
      chk({nm, "_valid"}, digit_valid, 1);
      chk({nm, "_busy_end"}, busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{pat: 0, exp_digit: 9, exp_score: 93};
    vecs[1] = '{pat: 1, exp_digit: 0, exp_score: 1376256};
    vecs[2] = '{pat: 2, exp_digit: 0, exp_score: 0};
    vecs[3] = '{pat: 3, exp_digit: 2, exp_score: 4};
    vecs[4] = '{pat: 4, exp_digit: 0, exp_score: -50};
    vecs[5] = '{pat: 5, exp_digit: 8, exp_score: 42};

    rst   = 1'b1;
    start = 1'b0;
`ifdef FC3_SCORE_READBACK_EN
    score_rd_addr = 4'd0;
`endif
    load(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digit", digit, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_score", max_score, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].pat);
      run($sformatf("vec%0d", i), vecs[i].exp_digit, vecs[i].exp_score, 0, 0, 1'b0);
`ifdef FC3_SCORE_READBACK_EN
      if (vecs[i].pat == 0) begin
        score_rd_addr = 4'd5;
        #1;
        chk("readback_addr5", score_rd_data, 89);
        score_rd_addr = 4'd12;
        #1;
        chk("readback_addr12", score_rd_data, 0);
      end
`endif
    end

    // Second start mid-run must be ignored.
    load(0);
    run("restart_ignored", 9, 93, 300, 0, 1'b0);

    // Reset mid-run aborts; a fresh start then completes normally.
    load(0);
    run("abort", 0, 0, 0, 400, 1'b0);
    load(5);
    run("after_abort", 8, 42, 0, 0, 1'b0);

    // Start held high through done relaunches immediately.
    load(3);
    run("held_start", 2, 4, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
